// File: rtl/acc_io_regs_pkg.sv
// Shared constants for the accumulator / I/O register stage and the skip-flag
// index used by the control sequencer.
package acc_io_regs_pkg;

    localparam int ACC_WIDTH  = 16;
    localparam int ACC_CHAR_W = 8;

    localparam int   AC_RST  = 0;
    localparam logic FGO_RST = 1'b1;

    typedef enum logic [1:0] {
        SKIP_AC_ZERO = 2'd0,
        SKIP_AC_NEG  = 2'd1,
        SKIP_E_ZERO  = 2'd2
    } skip_idx_e;

    localparam int SKIP_NUM = 3;

endpackage

// File: rtl/acc_io_regs_if.sv
// Strobe/data bundle between the control sequencer, ALU, device side and the
// accumulator/I/O register stage.
interface acc_io_regs_if
    import acc_io_regs_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH,
    parameter int CHAR_W = ACC_CHAR_W
);
    logic [WIDTH-1:0]  alu_outdata;
    logic              e_indata;
    logic              ff_en;
    logic              ac_load;
    logic              ac_clr;
    logic              ac_inc;
    logic              e_clr;
    logic              inp_ack;
    logic              out_load;
    logic              ien_set;
    logic              ien_clr;
    logic [CHAR_W-1:0] in_char;
    logic              in_strobe;
    logic              out_ack;

    logic [WIDTH-1:0]  ac_outdata;
    logic              e_outdata;
    logic [CHAR_W-1:0] inpr_outdata;
    logic [CHAR_W-1:0] outr_data;
    logic              out_valid;
    logic              fgi;
    logic              fgo;
    logic              in_overrun;
    logic              ac_zero;
    logic              ac_neg;
    logic              e_zero;
    logic              irq;

    modport master (
        output alu_outdata, e_indata, ff_en, ac_load, ac_clr, ac_inc, e_clr,
               inp_ack, out_load, ien_set, ien_clr, in_char, in_strobe, out_ack,
        input  ac_outdata, e_outdata, inpr_outdata, outr_data, out_valid, fgi,
               fgo, in_overrun, ac_zero, ac_neg, e_zero, irq
    );

    modport slave (
        input  alu_outdata, e_indata, ff_en, ac_load, ac_clr, ac_inc, e_clr,
               inp_ack, out_load, ien_set, ien_clr, in_char, in_strobe, out_ack,
        output ac_outdata, e_outdata, inpr_outdata, outr_data, out_valid, fgi,
               fgo, in_overrun, ac_zero, ac_neg, e_zero, irq
    );

endinterface

// File: rtl/acc_io_regs_io_flag_port.sv
// Data register plus handshake flag. A capture drives the flag to FLAG_CAP,
// a release drives it back; capture wins when both arrive together.
module io_flag_port #(
    parameter int W        = 8,
    parameter bit FLAG_RST = 1'b0,
    parameter bit FLAG_CAP = 1'b1,
    parameter bit GUARD    = 1'b0,
    parameter bit HAS_OVR  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_i,
    input  logic [W-1:0] cap_data_i,
    input  logic         rel_i,
    output logic [W-1:0] data_o,
    output logic         flag_o,
    output logic         ovr_o
);
    logic [W-1:0] data_q, data_d;
    logic         flag_q, flag_d;
    logic         ovr_q, ovr_d;
    logic         busy;

    // A guarded port refuses a capture while still holding an unreleased one.
    assign busy = GUARD && (flag_q == FLAG_CAP) && !rel_i;

    always_comb begin
        data_d = data_q;
        flag_d = flag_q;
        ovr_d  = ovr_q;
        if (cap_i && !busy) begin
            data_d = cap_data_i;
            flag_d = FLAG_CAP;
        end else if (rel_i) begin
            flag_d = ~FLAG_CAP;
        end
        if (!HAS_OVR) begin
            ovr_d = 1'b0;
        end else if (rel_i) begin
            ovr_d = 1'b0;
        end else if (cap_i && busy) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            flag_q <= FLAG_RST;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            flag_q <= flag_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_o = data_q;
    assign flag_o = flag_q;
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/acc_io_regs.sv
// Accumulator, E flip-flop, INPR/OUTR with their flags, IEN and the
// registered interrupt request, downstream of the ALU.
module acc_io_regs
    import acc_io_regs_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH,
    parameter int CHAR_W = ACC_CHAR_W
) (
    input  logic clk,
    input  logic reset_n,
    acc_io_regs_if.slave bus
);
    logic [WIDTH-1:0]    ac_q, ac_d;
    logic                e_q, e_d;
    logic                ien_q, ien_d;
    logic                irq_q, irq_d;
    logic                fgi, fgo;
    logic                out_ovr_unused;
    logic [SKIP_NUM-1:0] skip_flags;

    always_comb begin
        ac_d = ac_q;
        if (bus.ac_clr) begin
            ac_d = '0;
        end else if (bus.ac_load) begin
            ac_d = bus.alu_outdata;
        end else if (bus.ac_inc) begin
            ac_d = ac_q + WIDTH'(1);
        end

        e_d = e_q;
        if (bus.e_clr) begin
            e_d = 1'b0;
        end else if (bus.ff_en) begin
            e_d = bus.e_indata;
        end

        ien_d = ien_q;
        if (bus.ien_clr) begin
            ien_d = 1'b0;
        end else if (bus.ien_set) begin
            ien_d = 1'b1;
        end

        irq_d = ien_q & (fgi | fgo);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac_q  <= WIDTH'(AC_RST);
            e_q   <= 1'b0;
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            e_q   <= e_d;
            ien_q <= ien_d;
            irq_q <= irq_d;
        end
    end

    // Input side: a strobe while FGI is still set drops the character.
    io_flag_port #(
        .W        (CHAR_W),
        .FLAG_RST (1'b0),
        .FLAG_CAP (1'b1),
        .GUARD    (1'b1),
        .HAS_OVR  (1'b1)
    ) u_in_port (
        .clk        (clk),
        .rst_n      (reset_n),
        .cap_i      (bus.in_strobe),
        .cap_data_i (bus.in_char),
        .rel_i      (bus.inp_ack),
        .data_o     (bus.inpr_outdata),
        .flag_o     (fgi),
        .ovr_o      (bus.in_overrun)
    );

    // Output side: OUT is unguarded and simply overwrites OUTR.
    io_flag_port #(
        .W        (CHAR_W),
        .FLAG_RST (FGO_RST),
        .FLAG_CAP (1'b0),
        .GUARD    (1'b0),
        .HAS_OVR  (1'b0)
    ) u_out_port (
        .clk        (clk),
        .rst_n      (reset_n),
        .cap_i      (bus.out_load),
        .cap_data_i (ac_q[CHAR_W-1:0]),
        .rel_i      (bus.out_ack),
        .data_o     (bus.outr_data),
        .flag_o     (fgo),
        .ovr_o      (out_ovr_unused)
    );

    always_comb begin
        skip_flags               = '0;
        skip_flags[SKIP_AC_ZERO] = (ac_q == '0);
        skip_flags[SKIP_AC_NEG]  = ac_q[WIDTH-1];
        skip_flags[SKIP_E_ZERO]  = ~e_q;
    end

    assign bus.ac_outdata = ac_q;
    assign bus.e_outdata  = e_q;
    assign bus.fgi        = fgi;
    assign bus.fgo        = fgo;
    assign bus.out_valid  = ~fgo;
    assign bus.ac_zero    = skip_flags[SKIP_AC_ZERO];
    assign bus.ac_neg     = skip_flags[SKIP_AC_NEG];
    assign bus.e_zero     = skip_flags[SKIP_E_ZERO];
    assign bus.irq        = irq_q;

endmodule

// File: tb/tb_acc_io_regs.sv
// Directed bench for acc_io_regs: behavioural model checked every cycle plus
// hand-computed pins at the interesting points.
module tb_acc_io_regs;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    acc_io_regs_if #(.WIDTH(16), .CHAR_W(8)) bus ();

    acc_io_regs #(.WIDTH(16), .CHAR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state, reset values as initialisers.
    int m_ac = 0, m_inpr = 0, m_outr = 0;
    bit m_e = 0, m_fgi = 0, m_ovr = 0, m_fgo = 1, m_ien = 0, m_irq = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ac <= 0; m_e <= 0; m_inpr <= 0; m_outr <= 0;
            m_fgi <= 0; m_ovr <= 0; m_fgo <= 1; m_ien <= 0; m_irq <= 0;
        end else begin
            m_ac   <= bus.ac_clr ? 0 : bus.ac_load ? int'(bus.alu_outdata)
                    : bus.ac_inc ? (m_ac + 1) % 65536 : m_ac;
            m_e    <= bus.e_clr ? 1'b0 : bus.ff_en ? bus.e_indata : m_e;
            m_inpr <= (bus.in_strobe && (!m_fgi || bus.inp_ack)) ? int'(bus.in_char) : m_inpr;
            m_fgi  <= bus.in_strobe ? 1'b1 : bus.inp_ack ? 1'b0 : m_fgi;
            m_ovr  <= bus.inp_ack ? 1'b0 : (bus.in_strobe && m_fgi) ? 1'b1 : m_ovr;
            m_outr <= bus.out_load ? m_ac % 256 : m_outr;
            m_fgo  <= bus.out_load ? 1'b0 : bus.out_ack ? 1'b1 : m_fgo;
            m_ien  <= bus.ien_clr ? 1'b0 : bus.ien_set ? 1'b1 : m_ien;
            m_irq  <= m_ien && (m_fgi || m_fgo);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ac"},      32'(bus.ac_outdata),   32'(m_ac));
        chk({tag, ".e"},       32'(bus.e_outdata),    32'(m_e));
        chk({tag, ".inpr"},    32'(bus.inpr_outdata), 32'(m_inpr));
        chk({tag, ".outr"},    32'(bus.outr_data),    32'(m_outr));
        chk({tag, ".fgi"},     32'(bus.fgi),          32'(m_fgi));
        chk({tag, ".fgo"},     32'(bus.fgo),          32'(m_fgo));
        chk({tag, ".oval"},    32'(bus.out_valid),    32'(!m_fgo));
        chk({tag, ".ovr"},     32'(bus.in_overrun),   32'(m_ovr));
        chk({tag, ".ac_zero"}, 32'(bus.ac_zero),      32'(m_ac == 0));
        chk({tag, ".ac_neg"},  32'(bus.ac_neg),       32'(m_ac >= 32768));
        chk({tag, ".e_zero"},  32'(bus.e_zero),       32'(!m_e));
        chk({tag, ".irq"},     32'(bus.irq),          32'(m_irq));
    endtask

    always @(negedge clk) if (chk_en) check_model("cyc");

    task automatic idle();
        bus.alu_outdata = '0; bus.e_indata = 0; bus.ff_en = 0;
        bus.ac_load = 0; bus.ac_clr = 0; bus.ac_inc = 0; bus.e_clr = 0;
        bus.inp_ack = 0; bus.out_load = 0; bus.ien_set = 0; bus.ien_clr = 0;
        bus.in_char = '0; bus.in_strobe = 0; bus.out_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_ac(input logic [15:0] v);
        bus.alu_outdata = v; bus.ac_load = 1;
        step();
    endtask

    initial begin
        idle();
        // Strobes asserted while in reset must have no effect.
        bus.alu_outdata = 16'hFFFF; bus.ac_load = 1; bus.ff_en = 1; bus.e_indata = 1;
        bus.ien_set = 1; bus.in_strobe = 1; bus.in_char = 8'h77; bus.out_load = 1;
        @(negedge clk); chk_en = 1;
        repeat (3) @(posedge clk);
        #1; reset_n = 1; idle();
        step();
        chk("rst.ac", 32'(bus.ac_outdata), 32'h0);
        chk("rst.e", 32'(bus.e_outdata), 32'h0);
        chk("rst.fgo", 32'(bus.fgo), 32'h1);
        chk("rst.fgi", 32'(bus.fgi), 32'h0);
        chk("rst.oval", 32'(bus.out_valid), 32'h0);
        chk("rst.irq", 32'(bus.irq), 32'h0);

        bus.alu_outdata = 16'h8001; bus.e_indata = 1; bus.ac_load = 1; bus.ff_en = 1;
        step();
        chk("load.ac", 32'(bus.ac_outdata), 32'h8001);
        chk("load.e", 32'(bus.e_outdata), 32'h1);
        chk("load.neg", 32'(bus.ac_neg), 32'h1);
        chk("load.zero", 32'(bus.ac_zero), 32'h0);
        load_ac(16'hFFFF);
        bus.ac_inc = 1; step();
        chk("wrap.ac", 32'(bus.ac_outdata), 32'h0);
        chk("wrap.zero", 32'(bus.ac_zero), 32'h1);
        chk("wrap.e", 32'(bus.e_outdata), 32'h1);
        load_ac(16'h7FFE);
        for (int i = 0; i < 2; i++) begin bus.ac_inc = 1; step(); end
        chk("inc.ac", 32'(bus.ac_outdata), 32'h8000);
        chk("inc.neg", 32'(bus.ac_neg), 32'h1);

        load_ac(16'h1234);
        bus.ac_clr = 1; bus.ac_load = 1; bus.alu_outdata = 16'h5555; bus.ac_inc = 1;
        step();
        chk("prio.ac", 32'(bus.ac_outdata), 32'h0);
        bus.e_clr = 1; bus.ff_en = 1; bus.e_indata = 1;
        step();
        chk("prio.e", 32'(bus.e_outdata), 32'h0);
        chk("prio.ezero", 32'(bus.e_zero), 32'h1);

        bus.in_strobe = 1; bus.in_char = 8'h41; step();
        chk("in1.inpr", 32'(bus.inpr_outdata), 32'h41);
        chk("in1.fgi", 32'(bus.fgi), 32'h1);
        bus.in_strobe = 1; bus.in_char = 8'h42; step();
        chk("in2.inpr", 32'(bus.inpr_outdata), 32'h41);
        chk("in2.ovr", 32'(bus.in_overrun), 32'h1);
        bus.in_strobe = 1; bus.in_char = 8'h43; bus.inp_ack = 1; step();
        chk("in3.inpr", 32'(bus.inpr_outdata), 32'h43);
        chk("in3.fgi", 32'(bus.fgi), 32'h1);
        chk("in3.ovr", 32'(bus.in_overrun), 32'h0);
        bus.inp_ack = 1; step();
        chk("in4.fgi", 32'(bus.fgi), 32'h0);

        load_ac(16'h00A5);
        bus.out_load = 1; step();
        chk("out1.outr", 32'(bus.outr_data), 32'hA5);
        chk("out1.oval", 32'(bus.out_valid), 32'h1);
        bus.out_ack = 1; step();
        chk("out2.fgo", 32'(bus.fgo), 32'h1);
        bus.out_ack = 1; step();
        chk("out3.fgo", 32'(bus.fgo), 32'h1);
        load_ac(16'h3C5A);
        bus.out_load = 1; bus.out_ack = 1; step();
        chk("out4.fgo", 32'(bus.fgo), 32'h0);
        chk("out4.outr", 32'(bus.outr_data), 32'h5A);
        bus.out_ack = 1; step();

        bus.ien_set = 1; step();
        chk("irq0", 32'(bus.irq), 32'h0);
        step();
        chk("irq1", 32'(bus.irq), 32'h1);
        bus.ien_set = 1; bus.ien_clr = 1; step();
        step();
        chk("ienclr.irq", 32'(bus.irq), 32'h0);

        // Build up non-reset state, then drop reset between clock edges.
        bus.alu_outdata = 16'h1357; bus.ac_load = 1; bus.ff_en = 1; bus.e_indata = 1;
        bus.in_strobe = 1; bus.in_char = 8'h5A; bus.out_load = 1; bus.ien_set = 1;
        step();
        step();
        chk("pre.irq", 32'(bus.irq), 32'h1);
        chk("pre.ac", 32'(bus.ac_outdata), 32'h1357);
        #2 reset_n = 0;
        #1;
        chk("arst.ac", 32'(bus.ac_outdata), 32'h0);
        chk("arst.e", 32'(bus.e_outdata), 32'h0);
        chk("arst.inpr", 32'(bus.inpr_outdata), 32'h0);
        chk("arst.outr", 32'(bus.outr_data), 32'h0);
        chk("arst.fgo", 32'(bus.fgo), 32'h1);
        chk("arst.fgi", 32'(bus.fgi), 32'h0);
        chk("arst.irq", 32'(bus.irq), 32'h0);
        check_model("arst");
        @(posedge clk); #1 reset_n = 1;
        step();
        step();
        chk("post.ac", 32'(bus.ac_outdata), 32'h0);

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
